tuner_corr_seq: RTL

- Parametrised successor to the fixed 7-note tuner.
- Correlates a streaming audio sample against notes_p reference sinusoids using one time-multiplexed multiplier and a per-channel accumulator bank.
- At the end of each window_p-sample window it does a sequential argmax with a detection threshold, then presents the winning channel through a valid/ready output handshake.
- Sits between the audio input stream and the display/UART note formatter; the reference sinusoid generators sit outside and drive ref_i.

---
 rtl/tuner_corr_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/tuner_corr_seq.sv
// tuner_corr_seq: time-multiplexed correlator bank with windowed argmax and thresholded detection
module tuner_corr_seq #(
   parameter int width_p     = 12,
   parameter int frac_p      = 10,
   parameter int notes_p     = 7,
   parameter int window_p    = 65536,
   parameter int acc_width_p = 32
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic [width_p-1:0]           audio_i,
   input  logic [notes_p*width_p-1:0]   ref_i,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [acc_width_p-1:0]       thresh_i,
   output logic [$clog2(notes_p)-1:0]   index_o,
   output logic [acc_width_p-1:0]       mag_o,
   output logic                         detected_o,
   output logic                         valid_o,
   input  logic                         ready_i
);
   localparam int idx_w = $clog2(notes_p);
   localparam int cnt_w = $clog2(window_p + 1);
   localparam logic [idx_w-1:0] last_lp = idx_w'(notes_p - 1);
   localparam logic [cnt_w-1:0] win_last_lp = cnt_w'(window_p - 1);
   localparam logic signed [acc_width_p-1:0] max_lp = {1'b0, {(acc_width_p-1){1'b1}}};
   localparam logic signed [acc_width_p-1:0] min_lp = {1'b1, {(acc_width_p-1){1'b0}}};

   if (notes_p < 2 || window_p < 1 || acc_width_p < 2*width_p || frac_p >= width_p) begin : g_param_check
      $error("tuner_corr_seq: illegal parameter set");
   end

   typedef enum logic [1:0] {IDLE, MAC, SCAN, OUT} state_t;

   state_t                        state;
   logic signed [width_p-1:0]     audio_q;
   logic signed [width_p-1:0]     ref_q [notes_p];
   logic signed [acc_width_p-1:0] acc [notes_p];
   logic signed [2*width_p-1:0]   prod;
   logic signed [acc_width_p:0]   sum;
   logic signed [acc_width_p-1:0] cur, acc_next;
   logic [acc_width_p-1:0]        mag, best_mag, win_mag;
   logic [idx_w-1:0]              ptr, best_idx, win_idx;
   logic [cnt_w-1:0]              cnt;
   logic                          take;

   // One extra accumulator bit exposes overflow; the most negative value reports as +max
   always_comb begin
      cur      = acc[ptr];
      prod     = (2*width_p)'(audio_q) * (2*width_p)'(ref_q[ptr]);
      sum      = (acc_width_p+1)'(cur) + (acc_width_p+1)'(prod);
      acc_next = (sum[acc_width_p] != sum[acc_width_p-1]) ? (sum[acc_width_p] ? min_lp : max_lp)
                                                          : sum[acc_width_p-1:0];
      mag      = (cur == min_lp) ? max_lp : (cur[acc_width_p-1] ? -cur : cur);
      take     = (ptr == '0) || (mag > best_mag);
      win_idx  = take ? ptr : best_idx;
      win_mag  = take ? mag : best_mag;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state      <= IDLE;
         ready_o    <= 1'b1;
         valid_o    <= 1'b0;
         index_o    <= '0;
         mag_o      <= '0;
         detected_o <= 1'b0;
         cnt        <= '0;
         ptr        <= '0;
         best_idx   <= '0;
         best_mag   <= '0;
         audio_q    <= '0;
         for (int k = 0; k < notes_p; k++) begin
            acc[k]   <= '0;
            ref_q[k] <= '0;
         end
      end else begin
         case (state)
            IDLE: if (valid_i && ready_o) begin
               audio_q <= audio_i;
               for (int k = 0; k < notes_p; k++) ref_q[k] <= ref_i[k*width_p +: width_p];
               ptr     <= '0;
               ready_o <= 1'b0;
               state   <= MAC;
            end
            MAC: begin
               acc[ptr] <= acc_next;
               ptr      <= ptr + 1'b1;
               if (ptr == last_lp) begin
                  ptr <= '0;
                  cnt <= cnt + 1'b1;
                  if (cnt == win_last_lp) state <= SCAN;
                  else begin
                     state   <= IDLE;
                     ready_o <= 1'b1;
                  end
               end
            end
            SCAN: begin
               best_idx <= win_idx;
               best_mag <= win_mag;
               ptr      <= ptr + 1'b1;
               if (ptr == last_lp) begin
                  ptr        <= '0;
                  index_o    <= win_idx;
                  mag_o      <= win_mag;
                  detected_o <= win_mag >= thresh_i;
                  valid_o    <= 1'b1;
                  state      <= OUT;
               end
            end
            default: if (ready_i) begin
               for (int k = 0; k < notes_p; k++) acc[k] <= '0;
               cnt     <= '0;
               valid_o <= 1'b0;
               ready_o <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule
